// File: rtl/fsm_qos.sv
// Link-state controller for the four virtual-channel FIFOs of the QoS block.
// Optional macro FSM_ERR_RECOVER_EN lets ERROR return to INIT via set_init.
`timescale 1ns/1ps

module fsm_qos #(
    parameter int NUM_FIFO = 4,
    parameter int TH_W     = 3
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                set_init,
    input  logic [NUM_FIFO-1:0] empty,
    input  logic [NUM_FIFO-1:0] full,
    input  logic [NUM_FIFO-1:0] Pause,
    input  logic [NUM_FIFO-1:0] Continue,
    input  logic [TH_W-1:0]     umbral_bajo_in,
    input  logic [TH_W-1:0]     umbral_alto_in,
    output logic [2:0]          state,
    output logic                init_out,
    output logic                idle_out,
    output logic                active_out,
    output logic                error_out,
    output logic [NUM_FIFO-1:0] error_full,
    output logic [NUM_FIFO-1:0] paused,
    output logic [TH_W-1:0]     umbral_bajo_out,
    output logic [TH_W-1:0]     umbral_alto_out
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t              state_reg;
    logic [NUM_FIFO-1:0] error_full_reg;
    logic [NUM_FIFO-1:0] paused_reg;
    logic [NUM_FIFO-1:0] paused_next;
    logic [TH_W-1:0]     umbral_bajo_reg;
    logic [TH_W-1:0]     umbral_alto_reg;

    // Continue has priority over Pause on the same FIFO.
    generate
        for (genvar gi = 0; gi < NUM_FIFO; gi++) begin : g_paused
            assign paused_next[gi] = Continue[gi] ? 1'b0 :
                                     Pause[gi]    ? 1'b1 : paused_reg[gi];
        end
    endgenerate

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_RESET;
            error_full_reg  <= '0;
            paused_reg      <= '0;
            umbral_bajo_reg <= '0;
            umbral_alto_reg <= '0;
        end else begin
            case (state_reg)
                ST_RESET: state_reg <= ST_INIT;
                ST_INIT: begin
                    if (set_init) begin
                        umbral_bajo_reg <= umbral_bajo_in;
                        umbral_alto_reg <= umbral_alto_in;
                        paused_reg      <= '0;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_IDLE, ST_ACTIVE: begin
                    paused_reg <= paused_next;
                    if (|full) begin
                        state_reg      <= ST_ERROR;
                        error_full_reg <= full;
                    end else if (set_init) begin
                        state_reg <= ST_INIT;
                    end else if (state_reg == ST_IDLE && empty != '1) begin
                        state_reg <= ST_ACTIVE;
                    end else if (state_reg == ST_ACTIVE && empty == '1) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_ERROR: begin
`ifdef FSM_ERR_RECOVER_EN
                    if (set_init && full == '0) begin
                        state_reg      <= ST_INIT;
                        error_full_reg <= '0;
                        paused_reg     <= '0;
                    end
`else
                    state_reg <= ST_ERROR;
`endif
                end
                default: state_reg <= ST_RESET;
            endcase
        end
    end

    // Decodes follow the state register directly so they align with state.
    assign state           = state_reg;
    assign init_out        = (state_reg == ST_INIT);
    assign idle_out        = (state_reg == ST_IDLE);
    assign active_out      = (state_reg == ST_ACTIVE);
    assign error_out       = (state_reg == ST_ERROR);
    assign error_full      = error_full_reg;
    assign paused          = paused_reg;
    assign umbral_bajo_out = umbral_bajo_reg;
    assign umbral_alto_out = umbral_alto_reg;

endmodule

// File: tb/tb_fsm_qos.sv
// Scoreboard bench for fsm_qos: directed plan followed by random stimulus
// against a behavioural model of the link-state rules.
`timescale 1ns/1ps

module tb_fsm_qos;

    logic       CLK = 1'b0;
    logic       reset;
    logic       set_init;
    logic [3:0] empty, full, Pause, Continue;
    logic [2:0] umbral_bajo_in, umbral_alto_in;
    logic [2:0] state;
    logic       init_out, idle_out, active_out, error_out;
    logic [3:0] error_full, paused;
    logic [2:0] umbral_bajo_out, umbral_alto_out;

    fsm_qos #(.NUM_FIFO(4), .TH_W(3)) dut (
        .CLK(CLK), .reset(reset), .set_init(set_init),
        .empty(empty), .full(full), .Pause(Pause), .Continue(Continue),
        .umbral_bajo_in(umbral_bajo_in), .umbral_alto_in(umbral_alto_in),
        .state(state), .init_out(init_out), .idle_out(idle_out),
        .active_out(active_out), .error_out(error_out),
        .error_full(error_full), .paused(paused),
        .umbral_bajo_out(umbral_bajo_out), .umbral_alto_out(umbral_alto_out)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int       st;
        bit [3:0] ef;
        bit [3:0] pz;
        bit [2:0] lo;
        bit [2:0] hi;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Behavioural model: link state as a plain integer 0..4.
    int       m_st = 0;
    bit [3:0] m_ef = 0, m_pz = 0;
    bit [2:0] m_lo = 0, m_hi = 0;
    bit       rst_q = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit si, input bit [3:0] e,
                              input bit [3:0] f, input bit [3:0] p, input bit [3:0] c,
                              input bit [2:0] lo, input bit [2:0] hi);
        if (rst) begin
            m_st = 0; m_ef = 0; m_pz = 0; m_lo = 0; m_hi = 0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            if (si) begin m_lo = lo; m_hi = hi; m_pz = 0; end
            else m_st = 2;
        end else if (m_st == 2 || m_st == 3) begin
            m_pz = (m_pz | p) & ~c;
            if (f != 0) begin m_st = 4; m_ef = f; end
            else if (si) m_st = 1;
            else if (m_st == 2 && e != 4'hF) m_st = 3;
            else if (m_st == 3 && e == 4'hF) m_st = 2;
        end else begin
`ifdef FSM_ERR_RECOVER_EN
            if (si && f == 0) begin m_st = 1; m_ef = 0; m_pz = 0; end
`endif
        end
    endtask

    // Applies one cycle of inputs, predicts the post-edge outputs and returns
    // two time units after that edge (outputs settled, monitor already done).
    task automatic drive(input bit rst, input bit si, input bit [3:0] e,
                         input bit [3:0] f, input bit [3:0] p, input bit [3:0] c,
                         input bit [2:0] lo, input bit [2:0] hi);
        exp_t x;
        reset = rst; set_init = si; empty = e; full = f;
        Pause = p; Continue = c; umbral_bajo_in = lo; umbral_alto_in = hi;
        if (rst && !rst_q) begin
            #1;
            chk("async_rst_state", int'(state), 0);
            chk("async_rst_regs", int'({error_full, paused, umbral_bajo_out, umbral_alto_out}), 0);
        end
        rst_q = rst;
        model_step(rst, si, e, f, p, c, lo, hi);
        x.st = m_st; x.ef = m_ef; x.pz = m_pz; x.lo = m_lo; x.hi = m_hi;
        exp_q.push_back(x);
        @(posedge CLK);
        #2;
    endtask

    // Monitor: one comparison set per clock edge for which a prediction exists.
    initial begin
        exp_t x;
        bit [3:0] dec_exp;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                dec_exp = {x.st == 1, x.st == 2, x.st == 3, x.st == 4};
                txn++;
                chk("state", int'(state), x.st);
                chk("decode", int'({init_out, idle_out, active_out, error_out}), int'(dec_exp));
                chk("error_full", int'(error_full), int'(x.ef));
                chk("paused", int'(paused), int'(x.pz));
                chk("umbral_bajo", int'(umbral_bajo_out), int'(x.lo));
                chk("umbral_alto", int'(umbral_alto_out), int'(x.hi));
                $display("txn %0d: state=%0d error_full=%b paused=%b lo=%0d hi=%0d",
                         txn, state, error_full, paused, umbral_bajo_out, umbral_alto_out);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit       r, si;
        bit [3:0] e, f, p, c;
        // Reset asserted before any clock edge.
        reset = 1'b1; set_init = 0; empty = 4'hF; full = 0; Pause = 0; Continue = 0;
        umbral_bajo_in = 0; umbral_alto_in = 0;
        #1;
        chk("reset_no_clk_state", int'(state), 0);
        chk("reset_no_clk_dec", int'({init_out, idle_out, active_out, error_out}), 0);
        rst_q = 1'b1;

        // Init entry and threshold load
        drive(1, 0, 4'hF, 0, 0, 0, 0, 0);
        drive(0, 1, 4'hF, 0, 0, 0, 3'd2, 3'd6);
        chk("init_entry", int'(state), 1);
        drive(0, 1, 4'hF, 0, 0, 0, 3'd2, 3'd6);
        chk("thresholds", int'({umbral_bajo_out, umbral_alto_out}), int'({3'd2, 3'd6}));
        // Idle / active
        drive(0, 0, 4'hF, 0, 0, 0, 3'd5, 3'd1);
        chk("to_idle", int'(state), 2);
        chk("thr_held", int'(umbral_alto_out), 6);
        drive(0, 0, 4'hF, 0, 0, 0, 0, 0);
        chk("idle_hold", int'(state), 2);
        drive(0, 0, 4'h0, 0, 0, 0, 0, 0);
        chk("to_active", int'(state), 3);
        drive(0, 0, 4'hF, 0, 0, 0, 0, 0);
        chk("back_idle", int'(state), 2);
        drive(0, 0, 4'h0, 0, 0, 0, 0, 0);
        // Pause handling
        drive(0, 0, 4'h0, 0, 4'b0110, 0, 0, 0);
        chk("pause_set", int'(paused), 4'b0110);
        drive(0, 0, 4'h0, 0, 0, 0, 0, 0);
        chk("pause_hold", int'(paused), 4'b0110);
        drive(0, 0, 4'h0, 0, 4'b0110, 4'b0100, 0, 0);
        chk("continue_wins", int'(paused), 4'b0010);
        drive(0, 0, 4'h0, 0, 0, 4'b1010, 0, 0);
        chk("continue_clr", int'(paused), 0);
        // Error capture
        drive(0, 0, 4'h0, 4'd4, 0, 0, 0, 0);
        chk("err_state", int'(state), 4);
        chk("err_out", int'(error_out), 1);
        chk("err_full", int'(error_full), 4'b0100);
        drive(0, 0, 4'h0, 4'hF, 4'hF, 0, 0, 0);
        chk("err_frozen", int'({error_full, paused}), int'({4'b0100, 4'b0000}));
        // Priority: full beats set_init
        drive(1, 0, 4'hF, 0, 0, 0, 0, 0);
        drive(0, 0, 4'hF, 0, 0, 0, 0, 0);
        drive(0, 0, 4'hF, 0, 0, 0, 0, 0);
        chk("prio_idle", int'(state), 2);
        drive(0, 1, 4'hF, 4'd1, 0, 0, 0, 0);
        chk("prio_err", int'(state), 4);
        drive(0, 1, 4'hF, 4'd2, 0, 0, 0, 0);
        chk("err_full_blocks", int'(state), 4);
        drive(0, 1, 4'hF, 0, 0, 0, 0, 0);
`ifdef FSM_ERR_RECOVER_EN
        chk("recover_state", int'(state), 1);
        chk("recover_ef", int'(error_full), 0);
`else
        chk("no_recover_state", int'(state), 4);
        chk("no_recover_ef", int'(error_full), 1);
`endif
        drive(1, 0, 4'hF, 0, 0, 0, 0, 0);

        // Random phase
        for (int i = 0; i < 300; i++) begin
            r  = rst_q ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 39) == 0);
            si = ($urandom_range(0, 5) == 0);
            f  = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            case ($urandom_range(0, 2))
                0:       e = 4'hF;
                1:       e = 4'h0;
                default: e = 4'($urandom);
            endcase
            p = 4'($urandom & $urandom);
            c = 4'($urandom & $urandom & $urandom);
            drive(r, si, e, f, p, c, 3'($urandom), 3'($urandom));
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_qos.md
Name: fsm_qos

Overview:
- Control state machine of the PCIe QoS module.
- Consumes the per-FIFO status (empty, full) and flow-control requests (Pause, Continue) for the four virtual-channel FIFOs.
- Tracks the global link state: RESET, INIT, IDLE, ACTIVE, ERROR.
- Latches the FIFO watermark thresholds and keeps a per-FIFO paused vector for the arbiter.

Parameters:
- NUM_FIFO, 4, number of virtual-channel FIFOs; width of all per-FIFO vectors.
- TH_W, 3, width of the low/high watermark threshold values.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- set_init  input  1  request to enter or stay in INIT and load thresholds.
- empty  input  NUM_FIFO  per-FIFO empty flags.
- full  input  NUM_FIFO  per-FIFO full flags.
- Pause  input  NUM_FIFO  per-FIFO pause request, level-sampled each cycle.
- Continue  input  NUM_FIFO  per-FIFO resume request, level-sampled each cycle.
- umbral_bajo_in  input  TH_W  low watermark, loaded in INIT.
- umbral_alto_in  input  TH_W  high watermark, loaded in INIT.
- state  output  3  current state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- init_out, idle_out, active_out, error_out  output  1 each  one-hot decode of state.
- error_full  output  NUM_FIFO  full vector captured on entry to ERROR.
- paused  output  NUM_FIFO  sticky per-FIFO paused status.
- umbral_bajo_out, umbral_alto_out  output  TH_W each  latched thresholds.

Behaviour:
- Reset: reset=1 asynchronously forces state=RESET and clears error_full, paused and both thresholds to 0. All decode outputs are 0 in RESET.
- Registers: state, error_full, paused and thresholds update on the CLK rising edge. Decode outputs are combinational from the state register (Moore), so they are valid in the same cycle as state.
- RESET -> INIT on the first rising edge with reset=0, unconditionally.
- INIT:
  - Each edge with set_init=1 loads umbral_bajo_out and umbral_alto_out from the inputs; paused is cleared.
  - set_init=0 -> IDLE. Thresholds are not loaded on that edge and are held from then on.
- IDLE / ACTIVE priority, evaluated in this order:
  1. Any full bit set -> ERROR; error_full <= full on that same edge.
  2. set_init=1 -> INIT.
  3. From IDLE: empty != all-ones -> ACTIVE. From ACTIVE: empty == all-ones -> IDLE.
  4. Otherwise hold the current state.
- ERROR: held until reset. error_full and paused are frozen. Inputs are ignored, including set_init and further full bits.
- paused, per bit i, updated only in IDLE/ACTIVE and on the edge leaving them:
  - Continue[i]=1 clears the bit.
  - Otherwise Pause[i]=1 sets it.
  - Otherwise the bit holds.
  - Continue wins when Pause and Continue hit the same bit together.
- Reset mid-operation: immediate return to RESET with all registers cleared, with no clock edge needed.
- Unused state encodings 5-7 -> RESET on the next edge.

Optional Feature:
- Macro: FSM_ERR_RECOVER_EN.
- Defined: in ERROR, an edge with set_init=1 and full==0 -> INIT. error_full clears on that edge and paused clears.
- Undefined: ERROR exits only via reset, as specified above.

Test Plan:
1. Async reset and init entry: reset=1 with no clock -> state=0 and all outputs 0. Release reset with set_init=1 and umbral_bajo_in=2, umbral_alto_in=6 -> state=1 after one edge, thresholds 2/6.
2. Idle and active transitions:
   - From INIT, set_init=0 -> state=2.
   - empty=4'hF -> stays IDLE.
   - empty=4'h0 -> state=3 after one edge.
   - empty=4'hF -> state=2.
3. Pause handling in ACTIVE:
   - Pause=4'b0110 for one cycle -> paused=4'b0110; Pause=0 -> paused holds 4'b0110.
   - Pause=4'b0110 with Continue=4'b0100 -> paused=4'b0010.
   - Continue=4'b1010 -> paused=4'b0000.
4. Error capture:
   - In ACTIVE, full=4'd4 -> state=4, error_out=1, error_full=4'b0100.
   - full later changes to 4'hF -> error_full stays 4'b0100.
   - set_init=1 -> stays ERROR when FSM_ERR_RECOVER_EN is undefined.
5. Priority: in IDLE, full=4'd1 and set_init=1 on the same edge -> ERROR, not INIT.
6. Recovery (FSM_ERR_RECOVER_EN defined):
   - In ERROR, set_init=1 with full=0 -> state=1, error_full=0.
   - Same with full=4'd2 -> stays ERROR.
